// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - pipeline request/response and backing-memory bus bundle for dcache_ctrl
interface dcache_ctrl_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_be;
    logic          inv;
    logic [31:0]   rsp_rdata;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    // master is the environment (pipeline stage plus memory), slave is the cache
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, inv,
        input  rsp_rdata, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, inv,
        output rsp_rdata, stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
module dcache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int AW    = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    dcache_ctrl_if.slave bus
);
    localparam int WB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TB = AW - 2 - WB - IB;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t            state_q, state_d;
    logic [TB-1:0]     tag_mem  [LINES];
    logic [31:0]       data_mem [LINES][WORDS];
    logic [LINES-1:0]  valid_q;
    logic [WB-1:0]     cnt_q;
    logic              stall_c;
    logic [31:0]       rsp_c;

    logic [WB-1:0]     req_word;
    logic [IB-1:0]     req_idx;
    logic [TB-1:0]     req_tag;
    logic [WB-1:0]     cap_word;
    logic [IB-1:0]     cap_idx;
    logic [TB-1:0]     cap_tag;
    logic              hit;
    logic              cap_hit;
    logic              last_beat;
    logic              unused_addr_bits;

    assign req_word = bus.req_addr[WB+1:2];
    assign req_idx  = bus.req_addr[WB+IB+1:WB+2];
    assign req_tag  = bus.req_addr[AW-1:WB+IB+2];
    // the registered bus address doubles as the captured request address
    assign cap_word = bus.mem_addr[WB+1:2];
    assign cap_idx  = bus.mem_addr[WB+IB+1:WB+2];
    assign cap_tag  = bus.mem_addr[AW-1:WB+IB+2];
    assign unused_addr_bits = ^bus.req_addr[1:0];

    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign cap_hit   = valid_q[cap_idx] && (tag_mem[cap_idx] == cap_tag);
    assign last_beat = (state_q == REFILL) && bus.mem_ack && (cnt_q == WB'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        rsp_c   = '0;
        case (state_q)
            IDLE: begin
                if (hit) rsp_c = data_mem[req_idx][req_word];
                if (bus.req_valid) begin
                    if (bus.req_we) begin
                        stall_c = 1'b1;
                        state_d = WRITE;
                    end else if (!hit) begin
                        stall_c = 1'b1;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                stall_c = 1'b1;
                if (last_beat) state_d = IDLE;
            end
            WRITE: begin
                stall_c = ~bus.mem_ack;
                if (bus.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.stall     = stall_c & rst_n;
    assign bus.rsp_rdata = rsp_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            cnt_q         <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && bus.req_we) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= {bus.req_addr[AW-1:2], 2'b00};
                        bus.mem_wdata <= bus.req_wdata;
                        bus.mem_be    <= bus.req_be;
                    end else if (bus.req_valid && !hit) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= {bus.req_addr[AW-1:WB+2], {(WB+2){1'b0}}};
                        cnt_q        <= '0;
                    end else if (bus.inv && !bus.req_valid) begin
                        valid_q <= '0;
                    end
                end
                REFILL: begin
                    if (bus.mem_ack) begin
                        if (last_beat) begin
                            bus.mem_req      <= 1'b0;
                            valid_q[cap_idx] <= 1'b1;
                            cnt_q            <= '0;
                        end else begin
                            cnt_q                 <= cnt_q + WB'(1);
                            bus.mem_addr[WB+1:2]  <= cnt_q + WB'(1);
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // arrays carry no reset; valid_q alone decides whether their contents count
    always_ff @(posedge clk) begin
        if (state_q == REFILL && bus.mem_ack) begin
            data_mem[cap_idx][cnt_q] <= bus.mem_rdata;
            if (cnt_q == WB'(WORDS - 1)) tag_mem[cap_idx] <= cap_tag;
        end
        if (state_q == WRITE && bus.mem_ack && cap_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_be[b]) data_mem[cap_idx][cap_word][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl with a fixed-latency memory model
module tb_dcache_ctrl;
    localparam int LAT = 2;
    localparam int MISS_STALL = 1 + 4 * (LAT + 1);
    localparam int STORE_STALL = 1 + LAT;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    dcache_ctrl_if #(.AW(32)) bus ();

    dcache_ctrl #(.LINES(16), .WORDS(4), .AW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit   [31:0] mem_model [bit [31:0]];
    logic [31:0] log_addr  [$];
    logic        log_we    [$];
    logic [3:0]  log_be    [$];
    logic [31:0] log_wdata [$];
    int          lat_cnt;
    logic [31:0] wr_word;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {16'hD000, a[15:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_ack   <= 1'b0;
            bus.mem_rdata <= '0;
            lat_cnt       <= 0;
        end else begin
            bus.mem_ack <= 1'b0;
            if (bus.mem_req && !bus.mem_ack) begin
                if (lat_cnt == LAT - 1) begin
                    lat_cnt       <= 0;
                    bus.mem_ack   <= 1'b1;
                    bus.mem_rdata <= mem_read(bus.mem_addr);
                    log_addr.push_back(bus.mem_addr);
                    log_we.push_back(bus.mem_we);
                    log_be.push_back(bus.mem_be);
                    log_wdata.push_back(bus.mem_wdata);
                    if (bus.mem_we) begin
                        wr_word = mem_read(bus.mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (bus.mem_be[b]) wr_word[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                        mem_model[bus.mem_addr] = wr_word;
                    end
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end else begin
                lat_cnt <= 0;
            end
        end
    end

    task automatic do_load(input logic [31:0] a, output logic [31:0] d,
                           output int cycles, output bit timeout);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        cycles  = 0;
        timeout = 1'b0;
        #1;
        while (bus.stall) begin
            if (cycles > 200) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
            cycles++;
        end
        d = bus.rsp_rdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                            output int cycles, output bit timeout);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_be    = be;
        cycles  = 0;
        timeout = 1'b0;
        #1;
        while (bus.stall) begin
            if (cycles > 200) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
            cycles++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        tests_run++;
        if ({bus.stall, bus.mem_req, bus.mem_we, bus.mem_be} !== 7'b0) begin
            $display("FAIL reset_ctrl: stall/req/we/be=%b required 0000000", {bus.stall, bus.mem_req, bus.mem_we, bus.mem_be});
            tests_failed++;
        end
        tests_run++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0", bus.mem_addr, bus.mem_wdata, bus.rsp_rdata);
            tests_failed++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
            $display("FAIL reset_release: stall=%b mem_req=%b required 0 0", bus.stall, bus.mem_req);
            tests_failed++;
        end
    endtask

    task automatic test_refill;
        logic [31:0] d;
        int cyc, n0;
        bit to;
        n0 = log_addr.size();
        do_load(32'h0000_0104, d, cyc, to);
        tests_run++;
        if (to || d !== 32'h22) begin
            $display("FAIL refill_data: rdata=%h timeout=%0d required 00000022 0", d, to);
            tests_failed++;
        end
        tests_run++;
        if (cyc !== MISS_STALL) begin
            $display("FAIL refill_stall: stalled %0d cycles required %0d", cyc, MISS_STALL);
            tests_failed++;
        end
        tests_run++;
        if (log_addr.size() - n0 !== 4) begin
            $display("FAIL refill_beats: %0d bus beats required 4", log_addr.size() - n0);
            tests_failed++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (log_addr[n0+i] !== 32'h100 + 32'(4*i) || log_we[n0+i] !== 1'b0) begin
                    $display("FAIL refill_addr%0d: addr=%h we=%b required %h 0", i, log_addr[n0+i], log_we[n0+i], 32'h100 + 32'(4*i));
                    tests_failed++;
                end
            end
        end
    endtask

    task automatic test_hit;
        logic [31:0] d;
        int cyc, n0;
        bit to;
        n0 = log_addr.size();
        do_load(32'h0000_010C, d, cyc, to);
        tests_run++;
        if (d !== 32'h44 || cyc !== 0) begin
            $display("FAIL hit_data: rdata=%h stall_cycles=%0d required 00000044 0", d, cyc);
            tests_failed++;
        end
        tests_run++;
        if (log_addr.size() !== n0 || bus.mem_req !== 1'b0) begin
            $display("FAIL hit_bus: %0d beats mem_req=%b required 0 0", log_addr.size() - n0, bus.mem_req);
            tests_failed++;
        end
    endtask

    task automatic test_store_hit;
        logic [31:0] d, exp_word;
        int cyc, n0;
        bit to;
        exp_word = (32'h0000_0033 & ~32'h0000_FFFF) | (32'hAABB_CCDD & 32'h0000_FFFF);
        n0 = log_addr.size();
        do_store(32'h0000_0108, 32'hAABB_CCDD, 4'b0011, cyc, to);
        tests_run++;
        if (to || cyc !== STORE_STALL) begin
            $display("FAIL store_stall: stalled %0d cycles timeout=%0d required %0d 0", cyc, to, STORE_STALL);
            tests_failed++;
        end
        tests_run++;
        if (log_addr.size() - n0 !== 1) begin
            $display("FAIL store_beats: %0d bus beats required 1", log_addr.size() - n0);
            tests_failed++;
        end else begin
            tests_run++;
            if (log_we[n0] !== 1'b1 || log_be[n0] !== 4'b0011 || log_addr[n0] !== 32'h108 || log_wdata[n0] !== 32'hAABB_CCDD) begin
                $display("FAIL store_bus: we=%b be=%b addr=%h wdata=%h required 1 0011 00000108 aabbccdd",
                         log_we[n0], log_be[n0], log_addr[n0], log_wdata[n0]);
                tests_failed++;
            end
        end
        n0 = log_addr.size();
        do_load(32'h0000_0108, d, cyc, to);
        tests_run++;
        if (d !== exp_word || cyc !== 0 || log_addr.size() !== n0) begin
            $display("FAIL store_merge: rdata=%h stall=%0d beats=%0d required %h 0 0", d, cyc, log_addr.size() - n0, exp_word);
            tests_failed++;
        end
    endtask

    task automatic test_store_miss;
        logic [31:0] d;
        int cyc, n0;
        bit to;
        n0 = log_addr.size();
        do_store(32'h0000_2000, 32'h1234_5678, 4'b1111, cyc, to);
        tests_run++;
        if (to || cyc !== STORE_STALL || log_addr.size() - n0 !== 1) begin
            $display("FAIL store_miss_bus: stalled %0d beats %0d required %0d 1", cyc, log_addr.size() - n0, STORE_STALL);
            tests_failed++;
        end
        n0 = log_addr.size();
        do_load(32'h0000_2000, d, cyc, to);
        tests_run++;
        if (to || d !== 32'h1234_5678 || log_addr.size() - n0 !== 4 || cyc !== MISS_STALL) begin
            $display("FAIL store_no_alloc: rdata=%h beats=%0d stall=%0d required 12345678 4 %0d", d, log_addr.size() - n0, cyc, MISS_STALL);
            tests_failed++;
        end
    endtask

    task automatic test_conflict;
        logic [31:0] d;
        int cyc, n0;
        bit to;
        n0 = log_addr.size();
        do_load(32'h0000_1104, d, cyc, to);
        tests_run++;
        if (to || d !== 32'h66 || log_addr.size() - n0 !== 4) begin
            $display("FAIL conflict_fill: rdata=%h beats=%0d required 00000066 4", d, log_addr.size() - n0);
            tests_failed++;
        end else begin
            tests_run++;
            if (log_addr[n0] !== 32'h1100 || log_addr[n0+3] !== 32'h110C) begin
                $display("FAIL conflict_addr: first=%h last=%h required 00001100 0000110c", log_addr[n0], log_addr[n0+3]);
                tests_failed++;
            end
        end
        n0 = log_addr.size();
        do_load(32'h0000_0104, d, cyc, to);
        tests_run++;
        if (to || d !== 32'h22 || log_addr.size() - n0 !== 4) begin
            $display("FAIL conflict_evict: rdata=%h beats=%0d required 00000022 4", d, log_addr.size() - n0);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_refill;
        logic [31:0] d;
        int cyc, n0, budget;
        bit to;
        @(negedge clk);
        n0 = log_addr.size();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_1104;
        budget = 0;
        while (log_addr.size() < n0 + 2 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        tests_run++;
        if (log_addr.size() < n0 + 2) begin
            $display("FAIL midreset_wait: %0d beats seen required 2", log_addr.size() - n0);
            tests_failed++;
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            $display("FAIL midreset_outputs: mem_req=%b stall=%b rdata=%h required 0 0 0", bus.mem_req, bus.stall, bus.rsp_rdata);
            tests_failed++;
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n0 = log_addr.size();
        do_load(32'h0000_0104, d, cyc, to);
        tests_run++;
        if (to || d !== 32'h22 || log_addr.size() - n0 !== 4 || cyc !== MISS_STALL) begin
            $display("FAIL midreset_refill: rdata=%h beats=%0d stall=%0d required 00000022 4 %0d", d, log_addr.size() - n0, cyc, MISS_STALL);
            tests_failed++;
        end
    endtask

    task automatic test_inv;
        logic [31:0] d, exp_word;
        int cyc, n0;
        bit to;
        exp_word = (32'h0000_0033 & ~32'h0000_FFFF) | (32'hAABB_CCDD & 32'h0000_FFFF);
        n0 = log_addr.size();
        do_load(32'h0000_010C, d, cyc, to);
        tests_run++;
        if (d !== 32'h44 || log_addr.size() !== n0) begin
            $display("FAIL inv_prehit: rdata=%h beats=%0d required 00000044 0", d, log_addr.size() - n0);
            tests_failed++;
        end
        @(negedge clk);
        bus.inv = 1'b1;
        @(negedge clk);
        bus.inv = 1'b0;
        n0 = log_addr.size();
        do_load(32'h0000_010C, d, cyc, to);
        tests_run++;
        if (to || d !== 32'h44 || log_addr.size() - n0 !== 4) begin
            $display("FAIL inv_miss: rdata=%h beats=%0d required 00000044 4", d, log_addr.size() - n0);
            tests_failed++;
        end
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0108;
        bus.inv       = 1'b1;
        #1;
        tests_run++;
        if (bus.stall !== 1'b0 || bus.rsp_rdata !== exp_word) begin
            $display("FAIL inv_with_req: stall=%b rdata=%h required 0 %h", bus.stall, bus.rsp_rdata, exp_word);
            tests_failed++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.inv       = 1'b0;
        n0 = log_addr.size();
        do_load(32'h0000_0108, d, cyc, to);
        tests_run++;
        if (d !== exp_word || cyc !== 0 || log_addr.size() !== n0) begin
            $display("FAIL inv_ignored: rdata=%h stall=%0d beats=%0d required %h 0 0", d, cyc, log_addr.size() - n0, exp_word);
            tests_failed++;
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.inv       = 1'b0;
        mem_model[32'h100]  = 32'h11;
        mem_model[32'h104]  = 32'h22;
        mem_model[32'h108]  = 32'h33;
        mem_model[32'h10C]  = 32'h44;
        mem_model[32'h1100] = 32'h55;
        mem_model[32'h1104] = 32'h66;
        mem_model[32'h1108] = 32'h77;
        mem_model[32'h110C] = 32'h88;
        repeat (3) @(negedge clk);
        test_reset;
        test_refill;
        test_hit;
        test_store_hit;
        test_store_miss;
        test_conflict;
        test_reset_mid_refill;
        test_inv;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached required completion");
        $fatal(1, "watchdog");
    end
endmodule
